// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//
// Sequential binary-to-BCD converter for the ADC display chain. It takes the
// unsigned quotient from the divider and turns it into packed BCD digits for
// the seven-segment driver. The conversion uses shift-and-add-3
// (double-dabble) and processes one binary bit per clock. It also produces a
// leading-zero blanking mask.
//
// Handshake: a conversion is accepted on a rising edge where start=1 and
// in_ready=1. in_ready depends only on the FSM state, never on start. A start
// seen while busy=1 is dropped; nothing is queued. done is a one-cycle pulse,
// and in that cycle bcd/blank carry the new result. bcd/blank hold their
// previous values at all other times.
//
// Ports:
//   clk      in   1           rising-edge clock
//   rst      in   1           synchronous, active-high reset
//   start    in   1           conversion request, sampled only when in_ready=1
//   bin_in   in   WIDTH       unsigned value, captured on the accepting edge
//   in_ready out  1           idle and able to accept start (state == IDLE)
//   busy     out  1           conversion in progress (state == SHIFT)
//   done     out  1           one-cycle pulse, bcd/blank just updated
//   bcd      out  4*DIGITS    packed BCD; digit 0 is bits [3:0]
//   blank    out  DIGITS      bit i set when digit i and all higher digits are 0
//
// The FSM state can be observed directly: in_ready is high exactly in IDLE,
// and busy is high exactly in SHIFT.

module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int               CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST       = CW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      bin_sh;
  logic [4*DIGITS-1:0]   work;

  // Combinational results of one double-dabble iteration.
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   work_nxt;
  logic [WIDTH-1:0]      bin_nxt;
  logic [DIGITS-1:0]     blank_nxt;

  logic                  accept;
  logic                  last_iter;

  assign in_ready = (state == IDLE);
  assign busy     = (state == SHIFT);

  // One iteration: add 3 to every digit >= 5, then shift {work, bin} left.
  // The bit leaving the top digit is dropped; with 10^DIGITS > 2^WIDTH-1 it
  // is always zero.
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
    end
    {work_nxt, bin_nxt} = {adj, bin_sh} << 1;
  end

  // Blanking mask of the post-shift result: it propagates down from the top
  // digit and stops at the first nonzero digit. Digit 0 is always shown.
  always_comb begin
    blank_nxt = '0;
    blank_nxt[DIGITS-1] = (work_nxt[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 1; i--) begin
      blank_nxt[i] = (work_nxt[4*i +: 4] == 4'd0) && blank_nxt[i+1];
    end
    blank_nxt[0] = 1'b0;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_iter = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          last_iter = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      bin_sh <= '0;
      work   <= '0;
      bcd    <= '0;
      blank  <= BLANK_RST;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        bin_sh <= bin_in;
        work   <= '0;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        bin_sh <= bin_nxt;
        work   <= work_nxt;
        cnt    <= cnt + 1'b1;
        if (last_iter) begin
          bcd   <= work_nxt;
          blank <= blank_nxt;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
//
// Directed-vector bench for bin2bcd_seq (WIDTH=16, DIGITS=5). Expected BCD
// and blank values are hand-computed constants. Outputs are sampled #1 after
// the rising edge, and inputs are driven on the falling edge or #1 after the
// rising edge.

module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [4:0]  blank;

  int checks;
  int errors;
  int hold_bad;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .blank    (blank)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: wait for in_ready, then present start for exactly the accepting edge.
  task automatic start_conv(input logic [15:0] v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after acceptance until done. lat=0 means the wait timed out.
  // While waiting, bcd must keep the value it had before the conversion.
  task automatic wait_done(input logic [19:0] prev, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (bcd !== prev) hold_bad++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int t;
    int t1;
    int t2;
    logic [19:0] got_bcd;

    checks   = 0;
    errors   = 0;
    hold_bad = 0;
    rst      = 1'b1;
    start    = 1'b0;
    bin_in   = '0;

    // Reset / zero
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_bcd",   bcd,      20'h00000);
    check("rst_blank", blank,    5'b11110);
    check("rst_ready", in_ready, 1'b1);
    check("rst_busy",  busy,     1'b0);
    check("rst_done",  done,     1'b0);

    start_conv(16'd0);
    check("busy_after_accept", busy, 1'b1);
    wait_done(20'h00000, lat);
    check("zero_lat",   lat,   16);
    check("zero_bcd",   bcd,   20'h00000);
    check("zero_blank", blank, 5'b11110);

    // Full scale
    start_conv(16'd65535);
    wait_done(20'h00000, lat);
    check("fs_lat",   lat,      16);
    check("fs_bcd",   bcd,      20'h65535);
    check("fs_blank", blank,    5'b00000);
    check("fs_busy",  busy,     1'b0);
    check("fs_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 check("fs_done_single", done, 1'b0);

    // Mid value; bcd must hold 0x65535 until done
    hold_bad = 0;
    start_conv(16'd1234);
    wait_done(20'h65535, lat);
    check("mid_lat",   lat,      16);
    check("mid_bcd",   bcd,      20'h01234);
    check("mid_blank", blank,    5'b10000);
    check("mid_hold",  hold_bad, 0);

    // Ignored start during a conversion
    start_conv(16'd9999);
    repeat (4) @(posedge clk);
    #1;
    start  = 1'b1;
    bin_in = 16'd42;
    @(posedge clk);
    #1 start = 1'b0;
    ndone   = 0;
    got_bcd = '0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        got_bcd = bcd;
      end
    end
    check("ign_count", ndone,   1);
    check("ign_bcd",   got_bcd, 20'h09999);

    // Back-to-back with start held high
    @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd9999;
    t  = 0;
    t1 = -1;
    t2 = -1;
    for (int k = 0; k < 60 && t2 < 0; k++) begin
      @(posedge clk);
      #1;
      t++;
      if (done) begin
        if (t1 < 0) begin
          t1 = t;
          check("b2b_bcd0",   bcd,   20'h09999);
          check("b2b_blank0", blank, 5'b10000);
          bin_in = 16'd10000;
          @(posedge clk);
          #1;
          t++;
          start = 1'b0;
        end else begin
          t2 = t;
          check("b2b_bcd1",   bcd,   20'h10000);
          check("b2b_blank1", blank, 5'b00000);
        end
      end
    end
    start = 1'b0;
    check("b2b_gap", t2 - t1, 17);

    // Reset mid-conversion
    start_conv(16'd500);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mrst_bcd",   bcd,      20'h00000);
    check("mrst_blank", blank,    5'b11110);
    check("mrst_ready", in_ready, 1'b1);
    check("mrst_done",  done,     1'b0);
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("mrst_no_done", ndone, 0);
    start_conv(16'd500);
    wait_done(20'h00000, lat);
    check("mrst_lat",   lat,   16);
    check("mrst_bcd2",  bcd,   20'h00500);
    check("mrst_blank2", blank, 5'b11000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
